// File: rtl/usb_buf_pkg.sv
// usb_buf_pkg: shared widths, thresholds and pointer helpers for the USB buffer FIFOs.
package usb_buf_pkg;
   localparam int FIFO_WIDTH_D   = 8;
   localparam int FIFO_DEPTH_D   = 64;
   localparam int ADDR_WIDTH_D   = 6;
   localparam int AFULL_THRESH_D = 56;
   // Occupancy from wrap-bit pointers; modulo arithmetic handles the wrap.
   function automatic logic [ADDR_WIDTH_D:0] ptrCount(input logic [ADDR_WIDTH_D:0] wr, input logic [ADDR_WIDTH_D:0] rd);
      return wr - rd;
   endfunction
endpackage

// File: rtl/dpMem_dc.sv
// dpMem_dc: dual-port RAM, one write port and one registered read port on separate clocks.
module dpMem_dc #(
   parameter int FIFO_WIDTH = 8,
   parameter int FIFO_DEPTH = 64,
   parameter int ADDR_WIDTH = 6
) (
   input  logic                  wrClk,
   input  logic                  rdClk,
   input  logic [FIFO_WIDTH-1:0] dataIn,
   output logic [FIFO_WIDTH-1:0] dataOut,
   input  logic [ADDR_WIDTH-1:0] addrIn,
   input  logic [ADDR_WIDTH-1:0] addrOut,
   input  logic                  writeEn
);
   logic [FIFO_WIDTH-1:0] buffer [FIFO_DEPTH];
   always_ff @(posedge wrClk)
      if (writeEn) buffer[addrIn] <= dataIn;
   always_ff @(posedge rdClk)
      dataOut <= buffer[addrOut];
endmodule

// File: rtl/usb_fifo_ctrl.sv
// usb_fifo_ctrl: single-clock FIFO controller sequencing one dpMem_dc for the USB buffer path.
module usb_fifo_ctrl
   import usb_buf_pkg::*;
#(
   parameter int FIFO_WIDTH   = FIFO_WIDTH_D,
   parameter int FIFO_DEPTH   = FIFO_DEPTH_D,
   parameter int ADDR_WIDTH   = ADDR_WIDTH_D,
   parameter int AFULL_THRESH = AFULL_THRESH_D
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  fifoWEn,
   input  logic [FIFO_WIDTH-1:0] dataIn,
   input  logic                  fifoREn,
   output logic [FIFO_WIDTH-1:0] dataOut,
   output logic                  dataValid,
   input  logic                  flush,
   output logic                  full,
   output logic                  empty,
   output logic                  almostFull,
   output logic [ADDR_WIDTH:0]   numElements,
   output logic                  overflowErr,
   output logic                  underflowErr
);
   logic [ADDR_WIDTH:0] wrPtr, rdPtr;
   logic wrAcc, rdAcc;
   assign numElements = ptrCount(wrPtr, rdPtr);
   assign full        = (wrPtr[ADDR_WIDTH-1:0] == rdPtr[ADDR_WIDTH-1:0]) && (wrPtr[ADDR_WIDTH] != rdPtr[ADDR_WIDTH]);
   assign empty       = wrPtr == rdPtr;
   assign almostFull  = numElements >= (ADDR_WIDTH+1)'(AFULL_THRESH);
   assign wrAcc       = fifoWEn & ~full & ~flush;
   assign rdAcc       = fifoREn & ~empty & ~flush;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wrPtr        <= '0;
         rdPtr        <= '0;
         dataValid    <= 1'b0;
         overflowErr  <= 1'b0;
         underflowErr <= 1'b0;
      end else if (flush) begin
         wrPtr        <= '0;
         rdPtr        <= '0;
         dataValid    <= 1'b0;
         overflowErr  <= 1'b0;
         underflowErr <= 1'b0;
      end else begin
         if (wrAcc) wrPtr <= wrPtr + 1'b1;
         if (rdAcc) rdPtr <= rdPtr + 1'b1;
         if (fifoWEn && full) overflowErr <= 1'b1;
         if (fifoREn && empty) underflowErr <= 1'b1;
         dataValid <= rdAcc;
      end
   dpMem_dc #(
      .FIFO_WIDTH(FIFO_WIDTH),
      .FIFO_DEPTH(FIFO_DEPTH),
      .ADDR_WIDTH(ADDR_WIDTH)
   ) uMem (
      .wrClk  (clk),
      .rdClk  (clk),
      .dataIn (dataIn),
      .dataOut(dataOut),
      .addrIn (wrPtr[ADDR_WIDTH-1:0]),
      .addrOut(rdPtr[ADDR_WIDTH-1:0]),
      .writeEn(wrAcc)
   );
endmodule
